// File: rtl/mem_port_arbiter.sv
// Shared single-port memory arbiter between instruction fetch and data access.
// One transaction in flight; data has priority with a starvation guard for fetch.
module mem_port_arbiter #(
  parameter int ADDR_W     = 12,
  parameter int DATA_W     = 32,
  parameter int MEM_LAT    = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  input  logic              if_flush,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_valid,
  output logic              if_stall,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  input  logic [2:0]        dm_funct3,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              dm_valid,
  output logic              dm_stall,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [2:0]        mem_funct3,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int LAT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam int SC_W  = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;
  localparam logic [LAT_W-1:0] LAT_LOAD   = LAT_W'(MEM_LAT - 1);
  localparam logic [SC_W-1:0]  STARVE_TOP = SC_W'(STARVE_MAX);

  typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, WAIT = 2'd2} state_t;

  state_t            state_reg, state_next;
  logic              owner_dm_reg, owner_dm_next;
  logic              mem_we_reg, mem_we_next;
  logic [ADDR_W-1:0] mem_addr_reg, mem_addr_next;
  logic [DATA_W-1:0] mem_wdata_reg, mem_wdata_next;
  logic [2:0]        mem_funct3_reg, mem_funct3_next;
  logic [LAT_W-1:0]  lat_cnt_reg, lat_cnt_next;
  logic [SC_W-1:0]   starve_cnt_reg, starve_cnt_next;
  logic              cancel_reg, cancel_next;

  logic grant_dm, grant_if, complete;

  assign grant_dm = (state_reg == IDLE) && dm_req && !(if_req && starve_cnt_reg == STARVE_TOP);
  assign grant_if = (state_reg == IDLE) && if_req && !grant_dm;
  assign complete = (state_reg == WAIT) && (lat_cnt_reg == '0);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_reg      <= IDLE;
      owner_dm_reg   <= 1'b0;
      mem_we_reg     <= 1'b0;
      mem_addr_reg   <= '0;
      mem_wdata_reg  <= '0;
      mem_funct3_reg <= '0;
      lat_cnt_reg    <= '0;
      starve_cnt_reg <= '0;
      cancel_reg     <= 1'b0;
    end else begin
      state_reg      <= state_next;
      owner_dm_reg   <= owner_dm_next;
      mem_we_reg     <= mem_we_next;
      mem_addr_reg   <= mem_addr_next;
      mem_wdata_reg  <= mem_wdata_next;
      mem_funct3_reg <= mem_funct3_next;
      lat_cnt_reg    <= lat_cnt_next;
      starve_cnt_reg <= starve_cnt_next;
      cancel_reg     <= cancel_next;
    end
  end

  always_comb begin
    state_next      = state_reg;
    owner_dm_next   = owner_dm_reg;
    mem_we_next     = mem_we_reg;
    mem_addr_next   = mem_addr_reg;
    mem_wdata_next  = mem_wdata_reg;
    mem_funct3_next = mem_funct3_reg;
    lat_cnt_next    = lat_cnt_reg;
    starve_cnt_next = starve_cnt_reg;
    cancel_next     = cancel_reg;
    case (state_reg)
      IDLE: begin
        if (grant_dm) begin
          owner_dm_next   = 1'b1;
          mem_we_next     = dm_we;
          mem_addr_next   = dm_addr;
          mem_wdata_next  = dm_wdata;
          mem_funct3_next = dm_funct3;
          state_next      = ISSUE;
          // A DM grant with fetch waiting implies the count is below the cap.
          if (if_req)
            starve_cnt_next = starve_cnt_reg + SC_W'(1);
        end else if (grant_if) begin
          owner_dm_next   = 1'b0;
          mem_we_next     = 1'b0;
          mem_addr_next   = if_addr;
          mem_wdata_next  = '0;
          mem_funct3_next = 3'b010;
          starve_cnt_next = '0;
          state_next      = ISSUE;
        end
      end
      ISSUE: begin
        lat_cnt_next = LAT_LOAD;
        cancel_next  = cancel_reg | (if_flush & ~owner_dm_reg);
        state_next   = WAIT;
      end
      WAIT: begin
        if (complete) begin
          cancel_next = 1'b0;
          state_next  = IDLE;
        end else begin
          lat_cnt_next = lat_cnt_reg - LAT_W'(1);
          cancel_next  = cancel_reg | (if_flush & ~owner_dm_reg);
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Index 0 = fetch, 1 = data; a flush in the completion cycle also suppresses delivery.
  logic [1:0]             port_valid;
  logic [1:0][DATA_W-1:0] port_rdata;

  assign port_valid[0] = complete & ~owner_dm_reg & ~cancel_reg & ~if_flush;
  assign port_valid[1] = complete & owner_dm_reg;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_port
      assign port_rdata[gi] = port_valid[gi] ? mem_rdata : '0;
    end
  endgenerate

  assign if_valid   = port_valid[0];
  assign dm_valid   = port_valid[1];
  assign if_rdata   = port_rdata[0];
  assign dm_rdata   = port_rdata[1];
  assign if_stall   = if_req & ~if_valid;
  assign dm_stall   = dm_req & ~dm_valid;
  assign mem_en     = (state_reg == ISSUE);
  assign mem_we     = mem_we_reg;
  assign mem_addr   = mem_addr_reg;
  assign mem_wdata  = mem_wdata_reg;
  assign mem_funct3 = mem_funct3_reg;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: per-cycle vector table plus hand-written
// sequences for flush, starvation guard and asynchronous reset.
module tb_mem_port_arbiter;
  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        if_req = 1'b0, if_flush = 1'b0;
  logic [11:0] if_addr = '0;
  logic [31:0] if_rdata;
  logic        if_valid, if_stall;
  logic        dm_req = 1'b0, dm_we = 1'b0;
  logic [11:0] dm_addr = '0;
  logic [31:0] dm_wdata = '0;
  logic [2:0]  dm_funct3 = '0;
  logic [31:0] dm_rdata;
  logic        dm_valid, dm_stall;
  logic        mem_en, mem_we;
  logic [11:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [2:0]  mem_funct3;
  logic [31:0] mem_rdata = '0;

  int total = 0;
  int bad = 0;

  mem_port_arbiter #(.ADDR_W(12), .DATA_W(32), .MEM_LAT(2), .STARVE_MAX(4)) dut (
    .clock(clock), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
    .if_rdata(if_rdata), .if_valid(if_valid), .if_stall(if_stall),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_funct3(dm_funct3), .dm_rdata(dm_rdata), .dm_valid(dm_valid), .dm_stall(dm_stall),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_funct3(mem_funct3), .mem_rdata(mem_rdata)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic        if_req;
    logic [11:0] if_addr;
    logic        if_flush;
    logic        dm_req;
    logic        dm_we;
    logic [11:0] dm_addr;
    logic [31:0] dm_wdata;
    logic [2:0]  dm_f3;
    logic [31:0] mem_rdata;
    logic        e_mem_en;
    logic        e_mem_we;
    logic [11:0] e_mem_addr;
    logic [31:0] e_mem_wdata;
    logic [2:0]  e_mem_f3;
    logic        e_if_valid;
    logic [31:0] e_if_rdata;
    logic        e_dm_valid;
    logic [31:0] e_dm_rdata;
    logic        e_if_stall;
    logic        e_dm_stall;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  initial begin
    bit exp_dm[11];
    bit got_dm[11];
    int ng;

    // Fetch 0x010; simultaneous DM load 0x100 + fetch 0x014; store 0x104; DM drops req mid-flight.
    vecs.push_back('{1'b1,12'h010,1'b0, 1'b0,1'b0,12'h000,32'h0,3'b000, 32'h0,        1'b0,1'b0,12'h000,32'h0,3'b000,        1'b0,32'h0,1'b0,32'h0, 1'b1,1'b0});
    vecs.push_back('{1'b1,12'h010,1'b0, 1'b0,1'b0,12'h000,32'h0,3'b000, 32'h0,        1'b1,1'b0,12'h010,32'h0,3'b010,        1'b0,32'h0,1'b0,32'h0, 1'b1,1'b0});
    vecs.push_back('{1'b1,12'h010,1'b0, 1'b0,1'b0,12'h000,32'h0,3'b000, 32'hFFFFFFFF, 1'b0,1'b0,12'h000,32'h0,3'b000,        1'b0,32'h0,1'b0,32'h0, 1'b1,1'b0});
    vecs.push_back('{1'b1,12'h010,1'b0, 1'b0,1'b0,12'h000,32'h0,3'b000, 32'h00500093, 1'b0,1'b0,12'h000,32'h0,3'b000,        1'b1,32'h00500093,1'b0,32'h0, 1'b0,1'b0});
    vecs.push_back('{1'b0,12'h000,1'b0, 1'b0,1'b0,12'h000,32'h0,3'b000, 32'h12345678, 1'b0,1'b0,12'h000,32'h0,3'b000,        1'b0,32'h0,1'b0,32'h0, 1'b0,1'b0});
    vecs.push_back('{1'b1,12'h014,1'b0, 1'b1,1'b0,12'h100,32'h0,3'b010, 32'h0,        1'b0,1'b0,12'h000,32'h0,3'b000,        1'b0,32'h0,1'b0,32'h0, 1'b1,1'b1});
    vecs.push_back('{1'b1,12'h014,1'b0, 1'b1,1'b0,12'h100,32'h0,3'b010, 32'h0,        1'b1,1'b0,12'h100,32'h0,3'b010,        1'b0,32'h0,1'b0,32'h0, 1'b1,1'b1});
    vecs.push_back('{1'b1,12'h014,1'b0, 1'b1,1'b0,12'h100,32'h0,3'b010, 32'hFFFFFFFF, 1'b0,1'b0,12'h000,32'h0,3'b000,        1'b0,32'h0,1'b0,32'h0, 1'b1,1'b1});
    vecs.push_back('{1'b1,12'h014,1'b0, 1'b1,1'b0,12'h100,32'h0,3'b010, 32'h11223344, 1'b0,1'b0,12'h000,32'h0,3'b000,        1'b0,32'h0,1'b1,32'h11223344, 1'b1,1'b0});
    vecs.push_back('{1'b1,12'h014,1'b0, 1'b0,1'b0,12'h000,32'h0,3'b000, 32'h0,        1'b0,1'b0,12'h000,32'h0,3'b000,        1'b0,32'h0,1'b0,32'h0, 1'b1,1'b0});
    vecs.push_back('{1'b1,12'h014,1'b0, 1'b0,1'b0,12'h000,32'h0,3'b000, 32'h0,        1'b1,1'b0,12'h014,32'h0,3'b010,        1'b0,32'h0,1'b0,32'h0, 1'b1,1'b0});
    vecs.push_back('{1'b1,12'h014,1'b0, 1'b0,1'b0,12'h000,32'h0,3'b000, 32'h0,        1'b0,1'b0,12'h000,32'h0,3'b000,        1'b0,32'h0,1'b0,32'h0, 1'b1,1'b0});
    vecs.push_back('{1'b1,12'h014,1'b0, 1'b0,1'b0,12'h000,32'h0,3'b000, 32'hAABBCCDD, 1'b0,1'b0,12'h000,32'h0,3'b000,        1'b1,32'hAABBCCDD,1'b0,32'h0, 1'b0,1'b0});
    vecs.push_back('{1'b0,12'h000,1'b0, 1'b0,1'b0,12'h000,32'h0,3'b000, 32'h0,        1'b0,1'b0,12'h000,32'h0,3'b000,        1'b0,32'h0,1'b0,32'h0, 1'b0,1'b0});
    vecs.push_back('{1'b0,12'h000,1'b0, 1'b1,1'b1,12'h104,32'hDEADBEEF,3'b000, 32'h0, 1'b0,1'b0,12'h000,32'h0,3'b000,        1'b0,32'h0,1'b0,32'h0, 1'b0,1'b1});
    vecs.push_back('{1'b0,12'h000,1'b0, 1'b1,1'b1,12'h3FC,32'h0,3'b111, 32'h0,        1'b1,1'b1,12'h104,32'hDEADBEEF,3'b000, 1'b0,32'h0,1'b0,32'h0, 1'b0,1'b1});
    vecs.push_back('{1'b0,12'h000,1'b0, 1'b1,1'b1,12'h3FC,32'h0,3'b111, 32'h0,        1'b0,1'b0,12'h000,32'h0,3'b000,        1'b0,32'h0,1'b0,32'h0, 1'b0,1'b1});
    vecs.push_back('{1'b0,12'h000,1'b0, 1'b1,1'b1,12'h3FC,32'h0,3'b111, 32'h5A5A5A5A, 1'b0,1'b0,12'h000,32'h0,3'b000,        1'b0,32'h0,1'b1,32'h5A5A5A5A, 1'b0,1'b0});
    vecs.push_back('{1'b0,12'h000,1'b0, 1'b0,1'b0,12'h000,32'h0,3'b000, 32'h0,        1'b0,1'b0,12'h000,32'h0,3'b000,        1'b0,32'h0,1'b0,32'h0, 1'b0,1'b0});
    vecs.push_back('{1'b0,12'h000,1'b0, 1'b1,1'b0,12'h0C0,32'h0,3'b100, 32'h0,        1'b0,1'b0,12'h000,32'h0,3'b000,        1'b0,32'h0,1'b0,32'h0, 1'b0,1'b1});
    vecs.push_back('{1'b0,12'h000,1'b0, 1'b0,1'b0,12'h000,32'h0,3'b000, 32'h0,        1'b1,1'b0,12'h0C0,32'h0,3'b100,        1'b0,32'h0,1'b0,32'h0, 1'b0,1'b0});
    vecs.push_back('{1'b0,12'h000,1'b0, 1'b0,1'b0,12'h000,32'h0,3'b000, 32'h0,        1'b0,1'b0,12'h000,32'h0,3'b000,        1'b0,32'h0,1'b0,32'h0, 1'b0,1'b0});
    vecs.push_back('{1'b0,12'h000,1'b0, 1'b0,1'b0,12'h000,32'h0,3'b000, 32'h0BADF00D, 1'b0,1'b0,12'h000,32'h0,3'b000,        1'b0,32'h0,1'b1,32'h0BADF00D, 1'b0,1'b0});
    vecs.push_back('{1'b0,12'h000,1'b0, 1'b0,1'b0,12'h000,32'h0,3'b000, 32'h0,        1'b0,1'b0,12'h000,32'h0,3'b000,        1'b0,32'h0,1'b0,32'h0, 1'b0,1'b0});

    // Reset state
    repeat (2) @(posedge clock);
    #1;
    chk("reset mem_en", 32'(mem_en), 32'h0);
    chk("reset mem_we", 32'(mem_we), 32'h0);
    chk("reset mem_addr", 32'(mem_addr), 32'h0);
    chk("reset mem_wdata", mem_wdata, 32'h0);
    chk("reset mem_funct3", 32'(mem_funct3), 32'h0);
    chk("reset if_valid", 32'(if_valid), 32'h0);
    chk("reset dm_valid", 32'(dm_valid), 32'h0);
    reset = 1'b0;
    step();

    foreach (vecs[i]) begin
      if_req = vecs[i].if_req;   if_addr = vecs[i].if_addr; if_flush = vecs[i].if_flush;
      dm_req = vecs[i].dm_req;   dm_we = vecs[i].dm_we;     dm_addr = vecs[i].dm_addr;
      dm_wdata = vecs[i].dm_wdata; dm_funct3 = vecs[i].dm_f3; mem_rdata = vecs[i].mem_rdata;
      #2;
      chk($sformatf("v%0d mem_en", i), 32'(mem_en), 32'(vecs[i].e_mem_en));
      chk($sformatf("v%0d if_valid", i), 32'(if_valid), 32'(vecs[i].e_if_valid));
      chk($sformatf("v%0d if_rdata", i), if_rdata, vecs[i].e_if_rdata);
      chk($sformatf("v%0d dm_valid", i), 32'(dm_valid), 32'(vecs[i].e_dm_valid));
      chk($sformatf("v%0d dm_rdata", i), dm_rdata, vecs[i].e_dm_rdata);
      chk($sformatf("v%0d if_stall", i), 32'(if_stall), 32'(vecs[i].e_if_stall));
      chk($sformatf("v%0d dm_stall", i), 32'(dm_stall), 32'(vecs[i].e_dm_stall));
      if (vecs[i].e_mem_en) begin
        chk($sformatf("v%0d mem_we", i), 32'(mem_we), 32'(vecs[i].e_mem_we));
        chk($sformatf("v%0d mem_addr", i), 32'(mem_addr), 32'(vecs[i].e_mem_addr));
        chk($sformatf("v%0d mem_wdata", i), mem_wdata, vecs[i].e_mem_wdata);
        chk($sformatf("v%0d mem_funct3", i), 32'(mem_funct3), 32'(vecs[i].e_mem_f3));
      end
      $display("vec %0d: mem_en=%0b if_valid=%0b dm_valid=%0b", i, mem_en, if_valid, dm_valid);
      step();
    end

    // Flush: fetch 0x020 granted at f0, flush at f2, refetch 0x040 granted at f4
    if_req = 1'b1; if_addr = 12'h020; mem_rdata = 32'h0;
    #2; chk("flush f0 if_stall", 32'(if_stall), 32'h1); step();
    #2; chk("flush f1 mem_addr", 32'(mem_addr), 32'h020);
    chk("flush f1 mem_en", 32'(mem_en), 32'h1); step();
    if_flush = 1'b1;
    #2; chk("flush f2 if_valid", 32'(if_valid), 32'h0); step();
    if_flush = 1'b0; mem_rdata = 32'hCAFEF00D;
    #2; chk("flush f3 if_valid", 32'(if_valid), 32'h0);
    chk("flush f3 if_rdata", if_rdata, 32'h0);
    chk("flush f3 if_stall", 32'(if_stall), 32'h1); step();
    if_addr = 12'h040; mem_rdata = 32'h0;
    #2; chk("flush f4 mem_en", 32'(mem_en), 32'h0); step();
    #2; chk("flush f5 mem_en", 32'(mem_en), 32'h1);
    chk("flush f5 mem_addr", 32'(mem_addr), 32'h040); step();
    #2; chk("flush f6 if_valid", 32'(if_valid), 32'h0); step();
    mem_rdata = 32'h13579BDF;
    #2; chk("flush f7 if_valid", 32'(if_valid), 32'h1);
    chk("flush f7 if_rdata", if_rdata, 32'h13579BDF);
    $display("flush sequence: refetch if_valid=%0b", if_valid);
    step();
    if_req = 1'b0; mem_rdata = 32'h0;
    step();

    // Starvation guard: both requesters held continuously
    exp_dm = '{1'b1,1'b1,1'b1,1'b1,1'b0,1'b1,1'b1,1'b1,1'b1,1'b0,1'b1};
    got_dm = '{default: 1'b0};
    ng = 0;
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 12'h200; dm_funct3 = 3'b010; dm_wdata = 32'h0;
    if_req = 1'b1; if_addr = 12'h300;
    for (int c = 0; c < 120 && ng < 11; c++) begin
      #2;
      if (mem_en) begin
        got_dm[ng] = (mem_addr == 12'h200);
        $display("grant %0d: %s addr=0x%03h", ng, got_dm[ng] ? "DM" : "IF", mem_addr);
        ng++;
      end
      step();
    end
    chk("starve grant count", 32'(ng), 32'd11);
    for (int i = 0; i < ng; i++)
      chk($sformatf("starve grant%0d is_dm", i), 32'(got_dm[i]), 32'(exp_dm[i]));
    dm_req = 1'b0; if_req = 1'b0;
    repeat (4) step();

    // Asynchronous reset in WAIT of a DM load aborts it
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 12'h108; dm_funct3 = 3'b010;
    #2; chk("rst c0 dm_stall", 32'(dm_stall), 32'h1); step();
    #2; chk("rst c1 mem_addr", 32'(mem_addr), 32'h108); step();
    reset = 1'b1;
    #1;
    chk("rst async mem_en", 32'(mem_en), 32'h0);
    chk("rst async mem_addr", 32'(mem_addr), 32'h0);
    chk("rst async mem_funct3", 32'(mem_funct3), 32'h0);
    chk("rst async dm_valid", 32'(dm_valid), 32'h0);
    step();
    mem_rdata = 32'h77777777;
    #2; chk("rst c3 dm_valid", 32'(dm_valid), 32'h0);
    chk("rst c3 dm_rdata", dm_rdata, 32'h0); step();
    reset = 1'b0; mem_rdata = 32'h0;
    #2; chk("rst r0 mem_en", 32'(mem_en), 32'h0); step();
    #2; chk("rst r1 mem_en", 32'(mem_en), 32'h1);
    chk("rst r1 mem_addr", 32'(mem_addr), 32'h108); step();
    #2; chk("rst r2 dm_valid", 32'(dm_valid), 32'h0); step();
    mem_rdata = 32'h600DCAFE;
    #2; chk("rst r3 dm_valid", 32'(dm_valid), 32'h1);
    chk("rst r3 dm_rdata", dm_rdata, 32'h600DCAFE);
    $display("reset sequence: post-reset dm_valid=%0b", dm_valid);
    step();
    dm_req = 1'b0;
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

- Arbitrates a single-port unified memory between two requesters: the pipeline's instruction-fetch (IF) stage and memory-access (MEM) stage.
- One transaction is outstanding at a time. It is issued with a registered memory command and completes after a fixed memory latency.
- Data accesses have priority, with a starvation guard for fetch.
- Per-requester stall outputs freeze the PC/IF_ID and EX_MEM/MEM_WB pipeline registers while a requester waits.

## Interface

Parameters:
- ADDR_W, 12, byte address width of the shared memory
- DATA_W, 32, data width
- MEM_LAT, 2, cycles from issue cycle to read data valid (≥1)
- STARVE_MAX, 4, consecutive data grants tolerated while fetch waits

Ports:
- clock  in  1  clock
- reset  in  1  reset, asynchronous, active-high
- if_req  in  1  fetch request; held until if_valid
- if_addr  in  ADDR_W  fetch address
- if_flush  in  1  branch flush; cancels delivery of an in-flight fetch
- if_rdata  out  DATA_W  fetched instruction
- if_valid  out  1  one-cycle completion pulse
- if_stall  out  1  fetch waiting
- dm_req  in  1  data request; held until dm_valid
- dm_we  in  1  1 = store
- dm_addr  in  ADDR_W  data address
- dm_wdata  in  DATA_W  store data
- dm_funct3  in  3  access size/sign (RISC-V funct3)
- dm_rdata  out  DATA_W  load data
- dm_valid  out  1  one-cycle completion pulse (loads and stores)
- dm_stall  out  1  data access waiting
- mem_en  out  1  memory command strobe (issue cycle only)
- mem_we, mem_addr, mem_wdata, mem_funct3  out  1/ADDR_W/DATA_W/3  registered command
- mem_rdata  in  DATA_W  memory read data

## Operation

States:
- IDLE: no transaction outstanding.
- ISSUE: one cycle; mem_en=1.
- WAIT: latency countdown.

Arbitration happens only in IDLE.
- If dm_req=1 and not (if_req=1 and starve_cnt==STARVE_MAX), grant DM. Otherwise, if if_req=1, grant IF.
- On grant:
  - Latch owner, address, we, wdata and funct3 into the command registers.
  - IF commands use we=0, funct3=3'b010 and wdata=0.
  - Go to ISSUE.
- starve_cnt:
  - Increments, saturating at STARVE_MAX, on a DM grant while if_req=1.
  - Clears on an IF grant.
  - Unchanged otherwise.

Transaction progress:
- ISSUE loads lat_cnt=MEM_LAT-1, then goes to WAIT. With MEM_LAT=1 it goes directly to completion.
- WAIT decrements lat_cnt. When lat_cnt reaches 0 this is the completion cycle:
  - The owner's valid pulses for that cycle.
  - x_rdata = mem_rdata passthrough.
  - State returns to IDLE at the next edge.

Behaviour at boundaries:
- Requester inputs are ignored outside the grant cycle, so address or data changes mid-transaction have no effect.
- A requester that drops req mid-transaction still has its transaction completed and its valid pulsed.
- if_flush=1 in any cycle of an IF transaction, ISSUE through completion:
  - Sets a cancel flag.
  - if_valid is suppressed at completion and the flag clears.
  - The memory access itself still completes. The next IF request is arbitrated normally.
- Stall outputs (combinational):
  - if_stall = if_req & ~if_valid.
  - dm_stall = dm_req & ~dm_valid.
- rdata outputs are 0 when the corresponding valid is 0.

Reset (asynchronous):
- State IDLE; mem_en=0, mem_we=0.
- mem_addr, mem_wdata and mem_funct3 are 0.
- starve_cnt, lat_cnt and the cancel flag are 0.
- Both valids are 0.
- Reset mid-transaction aborts it: no valid is ever produced for it.

## Timing

- Grant in cycle T (IDLE with a request), mem_en=1 in cycle T+1, valid in cycle T+1+MEM_LAT.
- Next grant is possible in cycle T+2+MEM_LAT.
- MEM_LAT=2:
  - Request-to-valid latency is 3 cycles.
  - Throughput is one transaction per 4 cycles.
- Stall deasserts in the valid cycle, so the pipeline advances at the following edge.

## Test plan

1. **Reset:** assert reset mid-WAIT of a DM load → outputs clear immediately, no dm_valid, and the next request is granted normally after release.
2. **Single fetch, MEM_LAT=2:**
   - Stimulus: if_req=1, if_addr=0x010 at cycle 0; memory returns 0x00500093 at cycle 3.
   - Response: mem_en=1, mem_addr=0x010, mem_we=0, mem_funct3=010 in cycle 1. if_valid=1 with if_rdata=0x00500093 in cycle 3. if_stall=1 in cycles 0–2.
3. **Simultaneous requests:**
   - Stimulus: dm load 0x100 (funct3 010) and fetch 0x014, both at cycle 0.
   - Response: DM issued cycle 1, dm_valid cycle 3. IF issued cycle 5, if_valid cycle 7. if_stall=1 in cycles 0–6.
4. **Store:**
   - Stimulus: dm_we=1, addr 0x104, wdata 0xDEADBEEF, funct3 000.
   - Response: cycle 1 shows mem_we=1, mem_wdata=0xDEADBEEF, mem_funct3=000. dm_valid=1 in cycle 3.
5. **Starvation guard:** dm_req and if_req both held high continuously → grants go DM,DM,DM,DM,IF,DM…; starve_cnt is 0 after the IF grant.
6. **Flush:** if_flush pulsed in cycle 2 of a fetch granted at cycle 0 → no if_valid in cycle 3, state is IDLE by cycle 4, and a new fetch to 0x040 at cycle 4 gives if_valid at cycle 7.
